// File: rtl/urv_regfile_ng.sv
// urv_regfile_ng: dual-bank replicated register file with bypass and optional ECC scrubber
module urv_regfile_ng #(
   parameter int g_num_regs       = 32,
   parameter int g_with_ecc       = 0,
   parameter int g_scrub_interval = 64
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        d_stall_i,
   input  logic [4:0]  rf_rs1_i,
   input  logic [4:0]  rf_rs2_i,
   input  logic [4:0]  d_rs1_i,
   input  logic [4:0]  d_rs2_i,
   output logic [31:0] x_rs1_value_o,
   output logic [31:0] x_rs2_value_o,
   output logic        x_rs1_ecc_err_o,
   output logic        x_rs2_ecc_err_o,
   input  logic [4:0]  w_rd_i,
   input  logic [31:0] w_rd_value_i,
   input  logic [6:0]  w_rd_ecc_i,
   input  logic        w_rd_store_i,
   input  logic        w_bypass_rd_write_i,
   input  logic [31:0] w_bypass_rd_value_i,
   input  logic        scrub_en_i,
   output logic        scrub_busy_o,
   output logic [15:0] scrub_corrected_o,
   output logic        scrub_uncorr_o
);

   function automatic logic [6:0] f_ecc(input logic [31:0] d);
      logic [6:0] c;
      int p;
      c = '0;
      for (int j = 0; j < 32; j++) begin
         p = j + 3 + int'(j >= 1) + int'(j >= 4) + int'(j >= 11) + int'(j >= 26);
         if (d[j]) c = c ^ {1'b1, p[5:0]};
      end
      return c;
   endfunction

   function automatic logic f_ok(input logic [4:0] a);
      return a != 5'd0 && 32'(a) < g_num_regs;
   endfunction

   logic [38:0] r_bank0 [0:31];
   logic [38:0] r_bank1 [0:31];
   logic [38:0] r_rd1, r_rd2;
   logic        r_z1, r_z2, r_wb1, r_wb2;
   logic [31:0] r_wval;
   logic [4:0]  r_k;
   logic        w_st_ok, w_fix, w_wen, w_xb1, w_xb2;
   logic [4:0]  w_waddr;
   logic [38:0] w_wdata, w_fix_data;

   assign w_st_ok = w_rd_store_i && f_ok(w_rd_i);
   assign w_wen   = w_st_ok || w_fix;
   assign w_waddr = w_st_ok ? w_rd_i : r_k;
   assign w_wdata = w_st_ok ? {w_rd_ecc_i, w_rd_value_i} : w_fix_data;
   assign w_xb1   = w_bypass_rd_write_i && w_rd_i == d_rs1_i && w_rd_i != 5'd0;
   assign w_xb2   = w_bypass_rd_write_i && w_rd_i == d_rs2_i && w_rd_i != 5'd0;

   // Shared write port: pipeline store has priority, both replicas always written together
   always_ff @(posedge clk_i) begin
      if (w_wen) begin
         r_bank0[w_waddr] <= w_wdata;
         r_bank1[w_waddr] <= w_wdata;
      end
   end

   // Pipeline read ports, bank0 for rs1 and bank1 for rs2, held during stall
   always_ff @(posedge clk_i) begin
      if (!d_stall_i) begin
         r_rd1 <= r_bank0[rf_rs1_i];
         r_rd2 <= r_bank1[rf_rs2_i];
         r_z1  <= !f_ok(rf_rs1_i);
         r_z2  <= !f_ok(rf_rs2_i);
      end
   end

   // W-bypass flags: a valid store to the register being read this cycle
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wb1 <= 1'b0;
         r_wb2 <= 1'b0;
      end else if (!d_stall_i) begin
         r_wb1 <= w_st_ok && rf_rs1_i == w_rd_i;
         r_wb2 <= w_st_ok && rf_rs2_i == w_rd_i;
      end
   end

   // Last stored value, only pipeline stores update it
   always_ff @(posedge clk_i) begin
      if (w_rd_store_i) r_wval <= w_rd_value_i;
   end

   // Operand select: X-bypass, then W-bypass, then zero/out-of-range, then bank data
   always_comb begin
      x_rs1_value_o   = w_xb1 ? w_bypass_rd_value_i : r_wb1 ? r_wval : r_z1 ? 32'd0 : r_rd1[31:0];
      x_rs2_value_o   = w_xb2 ? w_bypass_rd_value_i : r_wb2 ? r_wval : r_z2 ? 32'd0 : r_rd2[31:0];
      x_rs1_ecc_err_o = g_with_ecc != 0 && !w_xb1 && !r_wb1 && !r_z1 && f_ecc(r_rd1[31:0]) != r_rd1[38:32];
      x_rs2_ecc_err_o = g_with_ecc != 0 && !w_xb2 && !r_wb2 && !r_z2 && f_ecc(r_rd2[31:0]) != r_rd2[38:32];
   end

   if (g_with_ecc != 0) begin : g_scrub
      typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_CHECK, S_FIX} t_state;
      t_state      r_state;
      logic [15:0] r_cnt, r_corr;
      logic [38:0] r_s0, r_s1;
      logic        r_unc;
      logic        w_hit, w_e0, w_e1;
      logic [4:0]  w_knext;
      assign w_hit      = w_rd_store_i && w_rd_i == r_k;
      assign w_e0       = f_ecc(r_s0[31:0]) != r_s0[38:32];
      assign w_e1       = f_ecc(r_s1[31:0]) != r_s1[38:32];
      assign w_knext    = r_k == 5'(g_num_regs - 1) ? 5'd1 : r_k + 5'd1;
      assign w_fix      = r_state == S_FIX && scrub_en_i && !rst_i && !w_rd_store_i;
      assign w_fix_data = w_e0 ? r_s1 : r_s0;
      assign scrub_busy_o      = r_state == S_READ || r_state == S_CHECK || r_state == S_FIX;
      assign scrub_corrected_o = r_corr;
      assign scrub_uncorr_o    = r_unc;

      // Scrub read port samples both replicas at index k
      always_ff @(posedge clk_i) begin
         if (r_state == S_READ) begin
            r_s0 <= r_bank0[r_k];
            r_s1 <= r_bank1[r_k];
         end
      end

      // Scrubber sequencing; a store to k abandons the current word without advancing
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            r_state <= S_IDLE;
            r_k     <= 5'd1;
            r_cnt   <= '0;
            r_corr  <= '0;
            r_unc   <= 1'b0;
         end else if (!scrub_en_i) begin
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_state <= S_WAIT;
                  r_cnt   <= 16'(g_scrub_interval - 1);
               end
               S_WAIT: begin
                  if (r_cnt == 16'd0) begin
                     r_state <= S_READ;
                     r_cnt   <= 16'(g_scrub_interval - 1);
                  end else begin
                     r_cnt <= r_cnt - 16'd1;
                  end
               end
               S_READ: r_state <= w_hit ? S_WAIT : S_CHECK;
               S_CHECK: begin
                  if (w_hit) begin
                     r_state <= S_WAIT;
                  end else if (w_e0 != w_e1) begin
                     r_state <= S_FIX;
                  end else begin
                     r_unc   <= r_unc | w_e0;
                     r_k     <= w_knext;
                     r_state <= S_WAIT;
                  end
               end
               S_FIX: begin
                  if (w_hit) begin
                     r_state <= S_WAIT;
                  end else if (!w_rd_store_i) begin
                     r_corr  <= r_corr + 16'(r_corr != 16'hFFFF);
                     r_k     <= w_knext;
                     r_state <= S_WAIT;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end else begin : g_noscrub
      assign r_k               = 5'd1;
      assign w_fix             = 1'b0;
      assign w_fix_data        = '0;
      assign scrub_busy_o      = 1'b0;
      assign scrub_corrected_o = '0;
      assign scrub_uncorr_o    = 1'b0;
   end

endmodule
